hazard_scoreboard: RTL and testbench

- Issue-side partner of the EX-stage forwarding unit. It tracks every in-flight register write and decides at ID whether an instruction may enter ID/EX.
- An instruction may proceed only when each source it reads will be available through the EX/MEM or MEM/WB forwarding paths.
- When a source is not yet available, the block stalls PC and IF/ID and injects a bubble into ID/EX.
- Sits between the decoder and the ID/EX pipeline register.

---
 rtl/hazard_scoreboard_pkg.sv | 26 ++
 rtl/hazard_scoreboard_if.sv | 35 +++
 rtl/hazard_scoreboard_chk.sv | 25 ++
 rtl/hazard_scoreboard_counter.sv | 30 +++
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 tb/tb_hazard_scoreboard.sv | 299 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the ID-stage hazard scoreboard and the EX-stage forwarding unit.
// Both blocks import this package, so their register and forwarding encodings stay consistent.
package hazard_scoreboard_pkg;

    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam int ZERO_REG = 0;

    // Forwarding mux selects used by the EX-stage partner; the scoreboard guarantees one of these covers every issued source.
    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    function automatic logic reg_is_tracked(input logic [31:0] addr, input logic hardwired);
        logic tracked_s;
        if (hardwired && (addr == 32'(ZERO_REG))) begin
            tracked_s = 1'b0;
        end else begin
            tracked_s = 1'b1;
        end
        return tracked_s;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decoder-to-scoreboard bundle: the ID-stage instruction fields in, the pipeline stall controls out.
interface hazard_scoreboard_if #(
    parameter int ADDR_W   = hazard_scoreboard_pkg::ADDR_W,
    parameter int NUM_REGS = hazard_scoreboard_pkg::NUM_REGS
);
    import hazard_scoreboard_pkg::*;

    logic                Id_valid;
    logic [ADDR_W-1:0]   Id_r1Address;
    logic [ADDR_W-1:0]   Id_r2Address;
    logic                Id_r1Used;
    logic                Id_r2Used;
    logic [ADDR_W-1:0]   Id_dest;
    logic                Id_regWrite;
    logic                Id_memRead;
    logic                flush;
    logic                stall;
    logic                ifIdWrite;
    logic                idExBubble;
    logic [NUM_REGS-1:0] pendingMask;
    logic [15:0]         stallCount;

    modport master (
        output Id_valid, Id_r1Address, Id_r2Address, Id_r1Used, Id_r2Used,
               Id_dest, Id_regWrite, Id_memRead, flush,
        input  stall, ifIdWrite, idExBubble, pendingMask, stallCount
    );

    modport slave (
        input  Id_valid, Id_r1Address, Id_r2Address, Id_r1Used, Id_r2Used,
               Id_dest, Id_regWrite, Id_memRead, flush,
        output stall, ifIdWrite, idExBubble, pendingMask, stallCount
    );

endinterface

// File: rtl/hazard_scoreboard_chk.sv
// Simulation-side properties for the hazard scoreboard: legal latency parameters and output relationships.
module hazard_scoreboard_chk #(
    parameter int LOAD_STALL = 1,
    parameter int ALU_STALL  = 0,
    parameter int CNT_W      = 2
) (
    input logic clk,
    input logic rst_n,
    input logic Id_valid,
    input logic flush,
    input logic stall,
    input logic ifIdWrite,
    input logic idExBubble
);

    localparam int MAX_CNT = (1 << CNT_W) - 1;

    a_load_stall_range: assert property (@(posedge clk) (LOAD_STALL >= 1) && (LOAD_STALL <= MAX_CNT));
    a_alu_stall_range:  assert property (@(posedge clk) (ALU_STALL >= 0) && (ALU_STALL <= MAX_CNT));

    a_ifid_inverse: assert property (@(posedge clk) disable iff (!rst_n) ifIdWrite == !stall);
    a_bubble_def:   assert property (@(posedge clk) disable iff (!rst_n) idExBubble == (stall || flush));
    a_stall_gated:  assert property (@(posedge clk) disable iff (!rst_n) stall |-> (Id_valid && !flush));

endmodule

// File: rtl/hazard_scoreboard_counter.sv
// One register's in-flight countdown: cycles left before its pending write is reachable by forwarding.
// An issue-time load replaces whatever count was running.
module scoreboard_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_val,
    output logic             pending
);

    logic [CNT_W-1:0] cnt_r;

    // Countdown with load override, saturating at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load_en) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign pending = (cnt_r != {CNT_W{1'b0}});

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: holds PC/IF-ID and bubbles ID/EX until every source an instruction
// reads is reachable through the EX/MEM or MEM/WB forwarding paths.
module hazard_scoreboard #(
    parameter int NUM_REGS           = hazard_scoreboard_pkg::NUM_REGS,
    parameter int ADDR_W             = hazard_scoreboard_pkg::ADDR_W,
    parameter int LOAD_STALL         = 1,
    parameter int ALU_STALL          = 0,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int CNT_W              = 2
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scoreboard_if.slave sb
);
    import hazard_scoreboard_pkg::*;

    localparam logic HARDWIRED = (ZERO_REG_HARDWIRED != 0);

    logic [NUM_REGS-1:0] pending_s;
    logic [NUM_REGS-1:0] load_en_s;
    logic [CNT_W-1:0]    load_val_s;
    logic                haz_a_s;
    logic                haz_b_s;
    logic                stall_s;
    logic                issue_s;
    logic                dest_tracked_s;
    logic [15:0]         stall_count_r;

    // Source hazards read the pre-update counts, so an instruction's own write never stalls itself
    always_comb begin
        haz_a_s = 1'b0;
        haz_b_s = 1'b0;
        if (sb.Id_r1Used && reg_is_tracked(32'(sb.Id_r1Address), HARDWIRED)) begin
            haz_a_s = pending_s[sb.Id_r1Address];
        end else begin
            haz_a_s = 1'b0;
        end
        if (sb.Id_r2Used && reg_is_tracked(32'(sb.Id_r2Address), HARDWIRED)) begin
            haz_b_s = pending_s[sb.Id_r2Address];
        end else begin
            haz_b_s = 1'b0;
        end
        stall_s = sb.Id_valid & ~sb.flush & (haz_a_s | haz_b_s);
        issue_s = sb.Id_valid & ~sb.flush & ~stall_s;
    end

    // Destination countdown load for the instruction leaving ID this cycle
    always_comb begin
        load_en_s      = {NUM_REGS{1'b0}};
        load_val_s     = CNT_W'(ALU_STALL);
        dest_tracked_s = reg_is_tracked(32'(sb.Id_dest), HARDWIRED);
        if (sb.Id_memRead) begin
            load_val_s = CNT_W'(LOAD_STALL);
        end else begin
            load_val_s = CNT_W'(ALU_STALL);
        end
        if (issue_s && sb.Id_regWrite && dest_tracked_s) begin
            load_en_s[sb.Id_dest] = 1'b1;
        end else begin
            load_en_s = {NUM_REGS{1'b0}};
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
        scoreboard_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_en  (load_en_s[gi]),
            .load_val (load_val_s),
            .pending  (pending_s[gi])
        );
    end

    // Saturating count of stalled cycles for performance monitoring
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= 16'h0000;
        end else if (stall_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign sb.stall       = stall_s;
    assign sb.ifIdWrite   = ~stall_s;
    assign sb.idExBubble  = stall_s | sb.flush;
    assign sb.pendingMask = pending_s;
    assign sb.stallCount  = stall_count_r;

    hazard_scoreboard_chk #(
        .LOAD_STALL (LOAD_STALL),
        .ALU_STALL  (ALU_STALL),
        .CNT_W      (CNT_W)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .Id_valid   (sb.Id_valid),
        .flush      (sb.flush),
        .stall      (stall_s),
        .ifIdWrite  (sb.ifIdWrite),
        .idExBubble (sb.idExBubble)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations share one ID-stage stimulus stream and are
// compared against a timestamp model (register r readable from cycle avail[r] onward).
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_valid, d_r1u, d_r2u, d_rw, d_mr, d_flush;
    logic [2:0] d_r1, d_r2, d_dest;

    logic        obs_stall [3];
    logic        obs_ifid  [3];
    logic        obs_bub   [3];
    logic [7:0]  obs_mask  [3];
    logic [15:0] obs_sc    [3];

    longint avail [3][8];
    longint cyc = 0;
    int     m_sc [3];
    int     pass_cnt = 0;
    int     chk_cnt  = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: LOAD_STALL=2/ALU_STALL=1; 2: wide counter LOAD_STALL=255/ALU_STALL=3
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int LS = (k == 0) ? 1 : ((k == 1) ? 2 : 255);
        localparam int AS = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
        localparam int CW = (k == 2) ? 8 : 2;

        hazard_scoreboard_if #(.ADDR_W(3), .NUM_REGS(8)) sif ();

        assign sif.Id_valid     = d_valid;
        assign sif.Id_r1Address = d_r1;
        assign sif.Id_r2Address = d_r2;
        assign sif.Id_r1Used    = d_r1u;
        assign sif.Id_r2Used    = d_r2u;
        assign sif.Id_dest      = d_dest;
        assign sif.Id_regWrite  = d_rw;
        assign sif.Id_memRead   = d_mr;
        assign sif.flush        = d_flush;
        assign obs_stall[k]     = sif.stall;
        assign obs_ifid[k]      = sif.ifIdWrite;
        assign obs_bub[k]       = sif.idExBubble;
        assign obs_mask[k]      = sif.pendingMask;
        assign obs_sc[k]        = sif.stallCount;

        hazard_scoreboard #(
            .NUM_REGS(8), .ADDR_W(3), .LOAD_STALL(LS), .ALU_STALL(AS),
            .ZERO_REG_HARDWIRED(1), .CNT_W(CW)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .sb    (sif)
        );
    end

    function automatic int f_lat(int k, logic is_load);
        if (is_load) return (k == 0) ? 1 : ((k == 1) ? 2 : 255);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic bit m_pend(int k, logic [2:0] r);
        return (r != 3'd0) && (cyc < avail[k][r]);
    endfunction

    function automatic bit m_stall(int k);
        return d_valid && !d_flush && ((d_r1u && m_pend(k, d_r1)) || (d_r2u && m_pend(k, d_r2)));
    endfunction

    function automatic logic [7:0] m_mask(int k);
        logic [7:0] m;
        for (int r = 0; r < 8; r++) m[r] = m_pend(k, 3'(r));
        return m;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 8; r++) avail[k][r] = 0;
            m_sc[k] = 0;
        end
    endtask

    // One clock: advance the model with the decision seen before the edge; return on the falling edge
    task automatic cycle();
        bit st [3];
        for (int k = 0; k < 3; k++) st[k] = m_stall(k);
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (st[k] && m_sc[k] < 65535) m_sc[k]++;
                if (d_valid && !d_flush && !st[k] && d_rw && d_dest != 3'd0)
                    avail[k][d_dest] = cyc + 1 + longint'(f_lat(k, d_mr));
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] a1, input logic u1, input logic [2:0] a2,
                         input logic u2, input logic [2:0] dst, input logic rw, input logic mr,
                         input logic fl);
        d_valid = v; d_r1 = a1; d_r1u = u1; d_r2 = a2; d_r2u = u2;
        d_dest = dst; d_rw = rw; d_mr = mr; d_flush = fl;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        model_reset();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++; if (obs_stall[k] !== 1'b0) $display("FAIL rst_stall[%0d] got=%0b exp=0", k, obs_stall[k]); else pass_cnt++;
            chk_cnt++; if (obs_ifid[k] !== 1'b1) $display("FAIL rst_ifid[%0d] got=%0b exp=1", k, obs_ifid[k]); else pass_cnt++;
            chk_cnt++; if (obs_bub[k] !== 1'b1) $display("FAIL rst_bubble_flush[%0d] got=%0b exp=1", k, obs_bub[k]); else pass_cnt++;
            chk_cnt++; if (obs_mask[k] !== 8'h00) $display("FAIL rst_mask[%0d] got=%0h exp=00", k, obs_mask[k]); else pass_cnt++;
            chk_cnt++; if (obs_sc[k] !== 16'h0000) $display("FAIL rst_count[%0d] got=%0h exp=0", k, obs_sc[k]); else pass_cnt++;
        end
        d_flush = 1'b0;
        #1;
        chk_cnt++; if (obs_bub[0] !== 1'b0) $display("FAIL rst_bubble_noflush got=%0b exp=0", obs_bub[0]); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_load_use();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
        #1;
        chk_cnt++; if (obs_stall[0] !== 1'b0) $display("FAIL lu_load_issue got=%0b exp=0", obs_stall[0]); else pass_cnt++;
        cycle();
        drive(1'b1, 3'd3, 1'b1, 3'd1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
        #1;
        chk_cnt++; if (obs_stall[0] !== 1'b1) $display("FAIL lu_stall got=%0b exp=1", obs_stall[0]); else pass_cnt++;
        chk_cnt++; if (obs_bub[0] !== 1'b1) $display("FAIL lu_bubble got=%0b exp=1", obs_bub[0]); else pass_cnt++;
        chk_cnt++; if (obs_ifid[0] !== 1'b0) $display("FAIL lu_ifid got=%0b exp=0", obs_ifid[0]); else pass_cnt++;
        chk_cnt++; if (obs_mask[0][3] !== 1'b1) $display("FAIL lu_mask3 got=%0b exp=1", obs_mask[0][3]); else pass_cnt++;
        cycle();
        #1;
        chk_cnt++; if (obs_stall[0] !== 1'b0) $display("FAIL lu_release got=%0b exp=0", obs_stall[0]); else pass_cnt++;
        chk_cnt++; if (obs_mask[0][3] !== 1'b0) $display("FAIL lu_mask3_clear got=%0b exp=0", obs_mask[0][3]); else pass_cnt++;
        chk_cnt++; if (obs_sc[0] !== 16'd1) $display("FAIL lu_count got=%0d exp=1", obs_sc[0]); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++; if (obs_stall[k] !== m_stall(k)) $display("FAIL lu_model_stall[%0d] got=%0b exp=%0b", k, obs_stall[k], m_stall(k)); else pass_cnt++;
        end
        cycle();
    endtask

    task automatic test_alu_forward();
        idle(4);
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        #1;
        chk_cnt++; if (obs_stall[0] !== 1'b0) $display("FAIL alu_issue got=%0b exp=0", obs_stall[0]); else pass_cnt++;
        cycle();
        drive(1'b1, 3'd1, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_cnt++; if (obs_stall[0] !== 1'b0) $display("FAIL alu_consumer got=%0b exp=0", obs_stall[0]); else pass_cnt++;
        chk_cnt++; if (obs_mask[0] !== 8'h00) $display("FAIL alu_mask got=%0h exp=00", obs_mask[0]); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++; if (obs_mask[k] !== m_mask(k)) $display("FAIL alu_model_mask[%0d] got=%0h exp=%0h", k, obs_mask[k], m_mask(k)); else pass_cnt++;
        end
        cycle();
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++; if (obs_stall[k] !== 1'b0) $display("FAIL zero_stall[%0d] got=%0b exp=0", k, obs_stall[k]); else pass_cnt++;
            chk_cnt++; if (obs_mask[k][0] !== 1'b0) $display("FAIL zero_mask0[%0d] got=%0b exp=0", k, obs_mask[k][0]); else pass_cnt++;
        end
        cycle();
    endtask

    task automatic test_flush();
        idle(4);
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0);
        #1;
        chk_cnt++; if (obs_stall[0] !== 1'b1) $display("FAIL fl_pre_stall got=%0b exp=1", obs_stall[0]); else pass_cnt++;
        d_flush = 1'b1;
        #1;
        chk_cnt++; if (obs_stall[0] !== 1'b0) $display("FAIL fl_stall got=%0b exp=0", obs_stall[0]); else pass_cnt++;
        chk_cnt++; if (obs_bub[0] !== 1'b1) $display("FAIL fl_bubble got=%0b exp=1", obs_bub[0]); else pass_cnt++;
        chk_cnt++; if (obs_ifid[0] !== 1'b1) $display("FAIL fl_ifid got=%0b exp=1", obs_ifid[0]); else pass_cnt++;
        cycle();
        drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_cnt++; if (obs_stall[0] !== 1'b0) $display("FAIL fl_fresh_reader got=%0b exp=0", obs_stall[0]); else pass_cnt++;
        chk_cnt++; if (obs_mask[0][2] !== 1'b0) $display("FAIL fl_mask2 got=%0b exp=0", obs_mask[0][2]); else pass_cnt++;
        chk_cnt++; if (obs_mask[0][7] !== 1'b0) $display("FAIL fl_no_load got=%0b exp=0", obs_mask[0][7]); else pass_cnt++;
        cycle();
    endtask

    task automatic test_load_stall2();
        idle(4);
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_cnt++; if (obs_stall[1] !== (c < 2)) $display("FAIL ls2_stall_c%0d got=%0b exp=%0b", c, obs_stall[1], (c < 2)); else pass_cnt++;
            cycle();
        end
        chk_cnt++; if (obs_sc[1] !== 16'(m_sc[1])) $display("FAIL ls2_count got=%0d exp=%0d", obs_sc[1], m_sc[1]); else pass_cnt++;
        idle(4);
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_cnt++; if (obs_stall[1] !== 1'b0) $display("FAIL ls2_independent got=%0b exp=0", obs_stall[1]); else pass_cnt++;
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            d_valid = ($urandom_range(0, 3) != 0);
            d_r1    = 3'($urandom_range(0, 7));
            d_r2    = 3'($urandom_range(0, 7));
            d_dest  = 3'($urandom_range(0, 7));
            d_r1u   = 1'($urandom_range(0, 1));
            d_r2u   = 1'($urandom_range(0, 1));
            d_rw    = ($urandom_range(0, 3) != 0);
            d_mr    = 1'($urandom_range(0, 1));
            d_flush = ($urandom_range(0, 7) == 0);
            #1;
            for (int k = 0; k < 3; k++) begin
                chk_cnt++; if (obs_stall[k] !== m_stall(k)) $display("FAIL rnd_stall[%0d] n=%0d got=%0b exp=%0b", k, n, obs_stall[k], m_stall(k)); else pass_cnt++;
                chk_cnt++; if (obs_ifid[k] !== !m_stall(k)) $display("FAIL rnd_ifid[%0d] n=%0d got=%0b exp=%0b", k, n, obs_ifid[k], !m_stall(k)); else pass_cnt++;
                chk_cnt++; if (obs_bub[k] !== (m_stall(k) || d_flush)) $display("FAIL rnd_bubble[%0d] n=%0d got=%0b exp=%0b", k, n, obs_bub[k], (m_stall(k) || d_flush)); else pass_cnt++;
                chk_cnt++; if (obs_mask[k] !== m_mask(k)) $display("FAIL rnd_mask[%0d] n=%0d got=%0h exp=%0h", k, n, obs_mask[k], m_mask(k)); else pass_cnt++;
                chk_cnt++; if (obs_sc[k] !== 16'(m_sc[k])) $display("FAIL rnd_count[%0d] n=%0d got=%0d exp=%0d", k, n, obs_sc[k], m_sc[k]); else pass_cnt++;
            end
            cycle();
        end
    endtask

    task automatic test_saturation();
        int n;
        n = 0;
        drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
        while (m_sc[2] < 65535 && n < 70000) begin
            cycle();
            n++;
        end
        chk_cnt++; if (n >= 70000) $display("FAIL sat_budget got=%0d cycles exp=<70000", n); else pass_cnt++;
        repeat (5) cycle();
        chk_cnt++; if (obs_sc[2] !== 16'hFFFF) $display("FAIL sat_hold got=%0h exp=ffff", obs_sc[2]); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++; if (obs_sc[k] !== 16'(m_sc[k])) $display("FAIL sat_model_count[%0d] got=%0d exp=%0d", k, obs_sc[k], m_sc[k]); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        idle(3);
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_cnt++; if (obs_stall[0] !== 1'b1) $display("FAIL ar_pre_stall got=%0b exp=1", obs_stall[0]); else pass_cnt++;
        chk_cnt++; if (obs_mask[0][4] !== 1'b1) $display("FAIL ar_pre_mask4 got=%0b exp=1", obs_mask[0][4]); else pass_cnt++;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++; if (obs_mask[k] !== 8'h00) $display("FAIL ar_mask[%0d] got=%0h exp=00", k, obs_mask[k]); else pass_cnt++;
            chk_cnt++; if (obs_stall[k] !== 1'b0) $display("FAIL ar_stall[%0d] got=%0b exp=0", k, obs_stall[k]); else pass_cnt++;
            chk_cnt++; if (obs_sc[k] !== 16'h0000) $display("FAIL ar_count[%0d] got=%0h exp=0", k, obs_sc[k]); else pass_cnt++;
        end
        cycle();
        rst_n = 1'b1;
        idle(1);
        #1;
        chk_cnt++; if (obs_sc[0] !== 16'h0000) $display("FAIL ar_post_count got=%0h exp=0", obs_sc[0]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_forward();
        test_zero_reg();
        test_flush();
        test_load_stall2();
        test_random();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
